control_sequencer: RTL
======================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 SHALL have port Clock, input, 1 bit: rising-edge clock for all state.
REQ-003 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port Start, input, 1 bit: begin or resume instruction sequencing.
REQ-005 SHALL have port IR, input, 32 bits: instruction register contents from the datapath.
REQ-006 SHALL have these 1-bit outputs, each an active-high datapath strobe: PCout, MARin, Zin, ZLOout, PCin, IncrementPC, Read, MDRin, MDRout, IRin, Yin.
REQ-007 SHALL have these 1-bit outputs for register-select encoding: Gra, Grb, Grc, Rin, Rout.
REQ-008 SHALL have port ALUControl, output, 5 bits: ALU operation code.
REQ-009 SHALL have port Run, output, 1 bit: high while sequencing.
REQ-010 SHALL have port IllegalOp, output, 1 bit: one-cycle pulse on an undefined opcode.

Function
REQ-011 SHALL decode the IR fields as: opcode = IR[31:27], Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15].
REQ-012 SHALL implement the states IDLE, T0, T1, T2, T3, T4, T5 and HALT, advancing at most one state per clock.
REQ-013 SHALL use these transitions: IDLE->T0 when Start=1; T0->T1->T2->T3 unconditionally; T3->T4 for a legal ALU opcode; T4->T5; T5->T0.
REQ-014 SHALL, in T3, go to HALT when the opcode is HALT (5'b11011), and go to T0 with IllegalOp=1 for that single cycle when the opcode is undefined.
REQ-015 SHALL leave HALT for T0 only when Start=1, and SHALL ignore Start in every state other than IDLE and HALT.
REQ-016 SHALL be a Moore machine: all outputs are a function of the current state and IR only, and every strobe not listed for a state is 0.
REQ-017 SHALL drive these strobes per state:
- T0: PCout, MARin, IncrementPC, Zin.
- T1: ZLOout, PCin, Read, MDRin.
- T2: MDRout, IRin.
- T3 (legal ALU opcode): Grb, Rout, Yin.
- T4: Grc, Rout, Zin, with ALUControl = table[opcode].
- T5: ZLOout, Gra, Rin.
REQ-018 SHALL drive ALUControl = 5'b00000 in every state except T4.
REQ-019 SHALL decode the opcode combinationally from IR during T3 and T4; IR is only guaranteed stable after the T2 edge.
REQ-020 SHALL drive Run=1 in T0–T5 and Run=0 in IDLE and HALT.
REQ-021 SHALL make the instruction latency exactly 6 cycles (T0–T5) per ALU instruction, with back-to-back instructions and no bubble.
REQ-022 SHALL map opcode 5'b00101 (and) to ALUControl 5'b01100; all other mappings come from the package table.

Reset
REQ-023 SHALL, when Reset=1 at a rising Clock edge, enter IDLE in any state, including mid-instruction.
REQ-024 SHALL drive all outputs to 0 on the cycle after reset, including Run, IllegalOp and ALUControl.
REQ-025 SHALL give Reset priority over Start when both are high at the same edge.

Structure
REQ-026 SHALL place the state encoding, the opcode constants (including HALT) and the opcode->ALUControl table with its legal-opcode mask in a shared package.
REQ-027 SHALL implement opcode-to-ALUControl decode and legality check as one sub-module, alu_op_decoder, which is purely combinational.
REQ-028 SHALL keep the FSM state in a single registered state variable with combinational output decode.

Verification
REQ-029 SHALL cover: reset, Start=1 for one cycle, IR=32'h28918000 -> T4 shows ALUControl=5'b01100 with Grc=Rout=Zin=1; T5 shows Gra=Rin=ZLOout=1; back at T0 exactly 6 cycles after leaving IDLE.
REQ-030 SHALL cover: IR opcode=5'b11011 -> HALT after T3 with Run=0; Start=1 -> next state T0 with Run=1.
REQ-031 SHALL cover: IR with an undefined opcode -> IllegalOp=1 for exactly one cycle in T3, no Yin/Rout asserted, T0 on the next cycle.
REQ-032 SHALL cover: Reset=1 asserted during T4 -> next cycle IDLE with all outputs 0; Start held high throughout -> no effect until Reset=0.
REQ-033 SHALL cover: two consecutive legal instructions -> second T0 immediately follows T5, and Start toggling mid-instruction changes nothing.
REQ-034 SHALL check, in every state, that at most one of PCout, ZLOout, MDRout and Rout is high (single bus driver).

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: state encoding, instruction
// layout, opcode constants and the opcode -> ALU control table.
package control_sequencer_pkg;

    localparam int unsigned OP_W  = 5;
    localparam int unsigned ALU_W = 5;
    localparam int unsigned REG_W = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T0   = 3'd1,
        T1   = 3'd2,
        T2   = 3'd3,
        T3   = 3'd4,
        T4   = 3'd5,
        T5   = 3'd6,
        HALT = 3'd7
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0]  opcode;
        logic [REG_W-1:0] ra;
        logic [REG_W-1:0] rb;
        logic [REG_W-1:0] rc;
        logic [14:0]      imm;
    } instr_t;

    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b01000;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b01001;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01010;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    // One bit per opcode; HALT is deliberately not an ALU opcode.
    localparam logic [31:0] LEGAL_MASK = 32'h0000_07F8;

    function automatic logic [ALU_W-1:0] alu_table(input logic [OP_W-1:0] op);
        logic [ALU_W-1:0] code;
        code = '0;
        case (op)
            OP_ADD:  code = 5'b00011;
            OP_SUB:  code = 5'b00100;
            OP_AND:  code = 5'b01100;
            OP_OR:   code = 5'b01101;
            OP_SHR:  code = 5'b00110;
            OP_SHL:  code = 5'b00111;
            OP_ROR:  code = 5'b01000;
            OP_ROL:  code = 5'b01001;
            default: code = '0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/control_sequencer_alu_op_decoder.sv
// Combinational opcode decode: ALU control code, legality and HALT detect.
module alu_op_decoder
    import control_sequencer_pkg::*;
(
    input  logic [OP_W-1:0]  opcode_i,
    output logic [ALU_W-1:0] alu_ctrl_o,
    output logic             legal_o,
    output logic             halt_o
);

    assign legal_o    = LEGAL_MASK[opcode_i];
    assign alu_ctrl_o = legal_o ? alu_table(opcode_i) : '0;
    assign halt_o     = (opcode_i == OP_HALT);

endmodule

// File: rtl/control_sequencer.sv
// Instruction control sequencer: fetch (T0-T2), decode/execute (T3-T5) for
// three-register ALU instructions, with HALT and illegal-opcode handling.
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        MARin,
    output logic        Zin,
    output logic        ZLOout,
    output logic        PCin,
    output logic        IncrementPC,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic [4:0]  ALUControl,
    output logic        Run,
    output logic        IllegalOp
);

    state_e           state_q, state_d;
    instr_t           instr;
    logic [ALU_W-1:0] dec_alu;
    logic             dec_legal;
    logic             dec_halt;
    logic             unused_ir_fields;

    assign instr = instr_t'(IR);
    // Register fields are consumed by the datapath's register-select logic.
    assign unused_ir_fields = ^{instr.ra, instr.rb, instr.rc, instr.imm};

    alu_op_decoder u_dec (
        .opcode_i   (instr.opcode),
        .alu_ctrl_o (dec_alu),
        .legal_o    (dec_legal),
        .halt_o     (dec_halt)
    );

    always_ff @(posedge Clock) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        PCout       = 1'b0;
        MARin       = 1'b0;
        Zin         = 1'b0;
        ZLOout      = 1'b0;
        PCin        = 1'b0;
        IncrementPC = 1'b0;
        Read        = 1'b0;
        MDRin       = 1'b0;
        MDRout      = 1'b0;
        IRin        = 1'b0;
        Yin         = 1'b0;
        Gra         = 1'b0;
        Grb         = 1'b0;
        Grc         = 1'b0;
        Rin         = 1'b0;
        Rout        = 1'b0;
        ALUControl  = '0;
        Run         = 1'b0;
        IllegalOp   = 1'b0;
        case (state_q)
            IDLE, HALT: begin
                if (Start) state_d = T0;
            end
            T0: begin
                Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncrementPC = 1'b1; Zin = 1'b1;
                state_d = T1;
            end
            T1: begin
                Run = 1'b1; ZLOout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
                state_d = T2;
            end
            T2: begin
                Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
                state_d = T3;
            end
            T3: begin
                Run = 1'b1;
                if (dec_legal) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    state_d = T4;
                end else if (dec_halt) begin
                    state_d = HALT;
                end else begin
                    IllegalOp = 1'b1;
                    state_d   = T0;
                end
            end
            T4: begin
                Run = 1'b1; Grc = 1'b1; Rout = 1'b1; Zin = 1'b1;
                ALUControl = dec_alu;
                state_d    = T5;
            end
            T5: begin
                Run = 1'b1; ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                state_d = T0;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
